// File: rtl/mod3_pkg.sv
// Residue definitions shared by the mod-3 frame transmitter and the checker side.
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DATA  = 2'b01,
    TRAIL = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    R0 = 2'b00,
    R1 = 2'b01,
    R2 = 2'b10
  } residue_t;

  // r' = (2r + b) mod 3; an unused encoding recovers to R0.
  function automatic residue_t next_residue(input residue_t r, input logic b);
    residue_t n;
    n = R0;
    case (r)
      R0:      n = b ? R1 : R0;
      R1:      n = b ? R0 : R2;
      R2:      n = b ? R2 : R1;
      default: n = R0;
    endcase
    return n;
  endfunction

  // Two-bit trailer T = (3 - r) mod 3, sent MSB first.
  function automatic logic [1:0] trailer(input residue_t r);
    logic [1:0] t;
    t = 2'b00;
    case (r)
      R1:      t = 2'b10;
      R2:      t = 2'b01;
      default: t = 2'b00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mod3_residue_acc.sv
// Running mod-3 residue of a serial MSB-first bit stream.
module mod3_residue_acc
  import mod3_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     enable,
  input  logic     data_bit,
  output residue_t residue
);

  // Clear wins over enable so a new frame always starts from R0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      residue <= R0;
    end else if (clear) begin
      residue <= R0;
    end else if (enable) begin
      residue <= next_residue(residue, data_bit);
    end
  end

endmodule

// File: rtl/mod3_frame_tx.sv
// Serial frame transmitter: MSB-first payload followed by a 2-bit trailer
// that makes the whole frame value divisible by 3.
module mod3_frame_tx
  import mod3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             tx_bit,
  output logic             tx_en,
  output logic             tx_last
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             bit_n, en_n, last_n;
  logic             acc_clear, acc_en;
  logic             accept;
  residue_t         residue;
  logic [1:0]       trl_final;
  logic [1:0]       trl_cur;

  // Ready in IDLE and in the second trailer cycle (TRAIL with cnt == 0).
  assign data_ready = !rst && ((state == IDLE) || ((state == TRAIL) && (cnt == '0)));
  assign accept     = data_valid && data_ready;

  // The accumulator only absorbs the last payload bit at the DATA->TRAIL edge,
  // so the first trailer bit is looked ahead through next_residue to avoid a bubble.
  assign trl_final = trailer(next_residue(residue, sr[WIDTH-1]));
  assign trl_cur   = trailer(residue);

  mod3_residue_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (acc_clear),
    .enable   (acc_en),
    .data_bit (sr[WIDTH-1]),
    .residue  (residue)
  );

  // State, shift register, counter and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      tx_bit  <= 1'b0;
      tx_en   <= 1'b0;
      tx_last <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
      tx_bit  <= bit_n;
      tx_en   <= en_n;
      tx_last <= last_n;
    end
  end

  // Next-state and next-output decode; outputs describe the following cycle.
  always_comb begin
    state_n   = state;
    sr_n      = sr;
    cnt_n     = cnt;
    bit_n     = 1'b0;
    en_n      = 1'b0;
    last_n    = 1'b0;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = DATA;
          sr_n      = data_in;
          cnt_n     = CW'(WIDTH - 1);
          bit_n     = data_in[WIDTH-1];
          en_n      = 1'b1;
          acc_clear = 1'b1;
        end
      end
      DATA: begin
        acc_en = 1'b1;
        en_n   = 1'b1;
        if (cnt == '0) begin
          state_n = TRAIL;
          cnt_n   = CW'(1);
          bit_n   = trl_final[1];
        end else begin
          sr_n  = {sr[WIDTH-2:0], 1'b0};
          cnt_n = cnt - CW'(1);
          bit_n = sr[WIDTH-2];
        end
      end
      TRAIL: begin
        if (cnt != '0) begin
          cnt_n  = '0;
          bit_n  = trl_cur[0];
          en_n   = 1'b1;
          last_n = 1'b1;
        end else if (accept) begin
          state_n   = DATA;
          sr_n      = data_in;
          cnt_n     = CW'(WIDTH - 1);
          bit_n     = data_in[WIDTH-1];
          en_n      = 1'b1;
          acc_clear = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        sr_n    = '0;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mod3_frame_tx.sv
// Directed and loopback checks for mod3_frame_tx with WIDTH=8.
module tb_mod3_frame_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx_bit;
  logic       tx_en;
  logic       tx_last;

  int checks = 0;
  int errors = 0;

  mod3_frame_tx #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_bit     (tx_bit),
    .tx_en      (tx_en),
    .tx_last    (tx_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with data_ready high or flags a timeout.
  task automatic wait_ready();
    int n = 0;
    while (!data_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) check_val("ready_timeout", 32'(data_ready), 32'd1);
  endtask

  // Offers one word, then samples the 10 frame cycles; returns at the 10th negedge.
  task automatic run_frame(input logic [7:0] w, output logic [9:0] frame,
                           output logic [9:0] env, output logic [9:0] lastv,
                           output logic [9:0] readyv);
    wait_ready();
    data_in    = w;
    data_valid = 1'b1;
    frame = '0; env = '0; lastv = '0; readyv = '0;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
      frame  = {frame[8:0], tx_bit};
      env    = {env[8:0], tx_en};
      lastv  = {lastv[8:0], tx_last};
      readyv = {readyv[8:0], data_ready};
    end
  endtask

  logic [9:0]  f, e, l, r;
  logic [19:0] f2, e2, l2, r2;
  logic [7:0]  wvec [6];
  logic [9:0]  fexp [6];
  logic [7:0]  w;
  logic        en_seen;
  int          res;

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0;
    wvec = '{8'h05, 8'h07, 8'h06, 8'hFF, 8'h00, 8'h01};
    fexp = '{10'h015, 10'h01E, 10'h018, 10'h3FC, 10'h000, 10'h006};

    // Reset state
    @(negedge clk); @(negedge clk);
    check_val("rst_ready", 32'(data_ready), 0);
    check_val("rst_en",    32'(tx_en),      0);
    check_val("rst_bit",   32'(tx_bit),     0);
    check_val("rst_last",  32'(tx_last),    0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", 32'(data_ready), 1);
    check_val("post_rst_en",    32'(tx_en),      0);

    // Isolated directed frames
    for (int k = 0; k < 6; k++) begin
      run_frame(wvec[k], f, e, l, r);
      check_val($sformatf("frame_%02h", wvec[k]), 32'(f), 32'(fexp[k]));
      check_val($sformatf("en_%02h", wvec[k]),     32'(e), 32'h3FF);
      check_val($sformatf("last_%02h", wvec[k]),   32'(l), 32'h001);
      check_val($sformatf("ready_%02h", wvec[k]),  32'(r), 32'h001);
      @(negedge clk);
      check_val($sformatf("idle_en_%02h", wvec[k]),    32'(tx_en),      0);
      check_val($sformatf("idle_ready_%02h", wvec[k]), 32'(data_ready), 1);
    end

    // Back-to-back: 0x05 then 0x07 with data_valid held
    wait_ready();
    data_in = 8'h05; data_valid = 1'b1;
    f2 = '0; e2 = '0; l2 = '0; r2 = '0;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      f2 = {f2[18:0], tx_bit};
      e2 = {e2[18:0], tx_en};
      l2 = {l2[18:0], tx_last};
      r2 = {r2[18:0], data_ready};
      if (i == 0)  data_in = 8'h07;
      if (i == 10) data_valid = 1'b0;
    end
    check_val("b2b_frames", 32'(f2), 32'({10'h015, 10'h01E}));
    check_val("b2b_en",     32'(e2), 32'hFFFFF);
    check_val("b2b_last",   32'(l2), 32'h00401);
    check_val("b2b_ready",  32'(r2), 32'h00401);
    @(negedge clk);
    check_val("b2b_idle_en", 32'(tx_en), 0);

    // data_valid toggled during DATA is ignored; the held word goes at the next ready
    wait_ready();
    data_in = 8'h06; data_valid = 1'b1;
    f = '0; e = '0; r = '0;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      f = {f[8:0], tx_bit};
      e = {e[8:0], tx_en};
      r = {r[8:0], data_ready};
      if (i == 0) data_valid = 1'b0;
      if (i >= 1 && i <= 6) begin
        data_valid = ~data_valid;
        data_in    = 8'hFF;
      end
      if (i == 7) begin
        data_valid = 1'b1;
        data_in    = 8'h01;
      end
    end
    check_val("tog_frame", 32'(f), 32'h018);
    check_val("tog_en",    32'(e), 32'h3FF);
    check_val("tog_ready", 32'(r), 32'h001);
    f = '0; e = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
      f = {f[8:0], tx_bit};
      e = {e[8:0], tx_en};
    end
    check_val("tog_next_frame", 32'(f), 32'h006);
    check_val("tog_next_en",    32'(e), 32'h3FF);
    @(negedge clk);

    // Reset at payload bit 4 of 0xA5
    wait_ready();
    data_in = 8'hA5; data_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
    end
    check_val("mid_en_before",  32'(tx_en),  1);
    check_val("mid_bit4",       32'(tx_bit), 0);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_en",    32'(tx_en),      0);
    check_val("mid_rst_bit",   32'(tx_bit),     0);
    check_val("mid_rst_last",  32'(tx_last),    0);
    check_val("mid_rst_ready", 32'(data_ready), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    en_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      en_seen = en_seen | tx_en;
    end
    check_val("mid_no_trailer", 32'(en_seen),    0);
    check_val("mid_ready",      32'(data_ready), 1);
    run_frame(8'h03, f, e, l, r);
    check_val("after_rst_frame", 32'(f), 32'h00C);
    check_val("after_rst_en",    32'(e), 32'h3FF);
    check_val("after_rst_last",  32'(l), 32'h001);

    // Loopback through a serial mod-3 checker model over random words
    for (int k = 0; k < 1000; k++) begin
      w = 8'($urandom_range(0, 255));
      run_frame(w, f, e, l, r);
      res = 0;
      for (int j = 9; j >= 0; j--) res = (2 * res + int'(f[j])) % 3;
      check_val("loop_residue", 32'(res), 0);
      check_val("loop_payload", 32'(f[9:2]), 32'(w));
      if (k % 10 == 0) begin
        check_val("loop_en",   32'(e), 32'h3FF);
        check_val("loop_last", 32'(l), 32'h001);
        for (int b = 0; b < 10; b++) begin
          res = 0;
          for (int j = 9; j >= 0; j--)
            res = (2 * res + int'(f[j] ^ (j == b))) % 3;
          check_val("loop_flip_flagged", 32'(res != 0), 1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod3_frame_tx.md
# mod3_frame_tx

Serial frame transmitter that pairs with the team's serial divisible-by-3 checker.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Tracks the running mod-3 residue of the bits already sent.
- Appends a 2-bit trailer so the value of the whole frame is ≡ 0 (mod 3).
- A downstream residue checker sitting in its zero-residue state after the last frame bit means the frame is intact.

## Interface
Parameters:
- WIDTH, default 8: payload bits per frame (≥2); frame length is WIDTH+2 bits.

Ports:
- clk  input  1  sole clock; everything updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- data_in  input  WIDTH  payload word; sampled only on acceptance.
- data_valid  input  1  source has a word; must hold data_in stable until accepted.
- data_ready  output  1  block can accept; acceptance happens at a rising edge where data_valid && data_ready.
- tx_bit  output  1  serial bit; 0 whenever tx_en is 0.
- tx_en  output  1  tx_bit carries a frame bit this cycle.
- tx_last  output  1  high only on the final trailer bit of a frame.

## Operation
- States: IDLE, DATA, TRAIL.
- IDLE:
  - data_ready=1 and tx_en=0.
  - On acceptance, data_in loads a WIDTH-bit shift register, the bit counter is set to WIDTH-1 and the residue r is set to 0, then go to DATA.
- DATA:
  - tx_bit is the shift-register MSB; shift left each cycle.
  - Residue update is r' = (2r + b) mod 3. Explicitly: R0: b0→R0, b1→R1. R1: b0→R2, b1→R0. R2: b0→R1, b1→R2.
  - After the WIDTH-th bit, go to TRAIL with trailer T = (3 − r_final) mod 3, where r_final = payload mod 3 (R0→00, R1→10, R2→01).
- TRAIL:
  - Two cycles, sending T MSB first. Frame value = payload·4 + T ≡ 0 (mod 3).
  - tx_last=1 on the second trailer cycle.
- Back-to-back:
  - data_ready is also 1 during the second trailer cycle.
  - On acceptance there, go directly to DATA so the next frame's MSB follows with no gap.
  - Otherwise return to IDLE.
- data_ready=0 in DATA and in the first trailer cycle. data_valid in those cycles is ignored, with no side effects.
- Unused state encoding recovers to IDLE.
- Reset mid-frame:
  - tx_en, tx_bit and tx_last drop to 0 asynchronously.
  - The frame is aborted with no trailer, and the shift register, counter and residue are cleared.
- Reset values: tx_bit=0, tx_en=0, tx_last=0, data_ready=0 while rst=1. data_ready=1 from the first cycle after release (state IDLE).
- The data_in value is irrelevant to control flow; every WIDTH-bit pattern, including all-zero and all-one, produces a legal frame.

## Timing
- Acceptance at edge k → tx_en=1 for cycles k+1 … k+WIDTH+2. The payload MSB is on tx_bit in cycle k+1, the trailer is in cycles k+WIDTH+1 and k+WIDTH+2, and tx_last is in k+WIDTH+2.
- Latency from acceptance to first bit: 1 cycle.
- Throughput: one frame per WIDTH+2 cycles with data_valid held continuously.
- tx_bit, tx_en and tx_last are registered outputs; data_ready is decoded from the state register (gated by rst) with no combinational path from data_valid.
- The trailer depends on the residue including the last payload bit and must be correct in the cycle TRAIL is entered, so no bubble is allowed.

## Structure
- Package mod3_pkg:
  - state enum (IDLE/DATA/TRAIL);
  - residue encodings R0/R1/R2;
  - a function next_residue(r, b);
  - a function trailer(r) returning the 2-bit T.
- The package is shared with the checker side so both ends use one residue definition.
- Sub-module mod3_residue_acc:
  - inputs: clk, rst, clear, enable, bit;
  - output: the 2-bit residue;
  - instantiated once, driven with clear on acceptance and enable in DATA.
- Top level holds the FSM, shift register and counter (clog2(WIDTH) bits).

## Test plan
- WIDTH=8, single frame 0x05 (r=2) → tx_bit 0000_0101 then 01; tx_en for 10 cycles; frame 21; tx_last on bit 10.
- Frames 0x07, 0x06 and 0xFF → trailers 10, 00 and 00; frame values 30, 24 and 1020.
- data_valid held with 0x05 then 0x07 → data_ready high in trailer cycle 2, 20 contiguous tx_en cycles, no gap, two tx_last pulses.
- data_valid toggled during DATA → no acceptance, frame unaffected; word taken only at the next data_ready.
- rst asserted at payload bit 4 of 0xA5 → outputs 0 immediately, no trailer; after release data_ready=1 and the next frame 0x03 is correct (trailer 00).
- Loopback into a serial mod-3 checker model → checker residue 0 after every tx_last across 1000 random words; a single flipped bit is always flagged.
